// File: rtl/data_memory_responder.sv
// Word-addressed data-memory responder: accepts one load/store per req/ready handshake and
// answers with a single-cycle response pulse after LATENCY cycles.
//
// state | meaning
// IDLE  | nothing outstanding, ready for a request
// WAIT  | request captured, counting down wait cycles, not ready
// RESP  | response pulse; access committed on entry, ready for a back-to-back request
module data_memory_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        error
);

    localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        error_q;

    logic [31:0] ram_q [DEPTH_WORDS];

    logic        accept;
    logic        enter_resp;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [31:0] offset;
    logic        acc_err;
    logic [IDX_W-1:0] idx;

    assign ready      = (state_q != WAIT);
    assign resp_valid = (state_q == RESP);
    assign rdata      = rdata_q;
    assign error      = error_q;
    assign accept     = req && ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else if (state_q == RESP) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY == 1 the access edge is the accept edge, so the live request is used.
    assign enter_resp = (state_d == RESP);
    assign acc_we     = (state_q == WAIT) ? we_q    : we;
    assign acc_addr   = (state_q == WAIT) ? addr_q  : addr;
    assign acc_wdata  = (state_q == WAIT) ? wdata_q : wdata;

    assign offset  = acc_addr - BASE_ADDR;
    assign acc_err = (offset[1:0] != 2'b00) || (acc_addr < BASE_ADDR) || ({1'b0, offset} >= SPAN);
    assign idx     = offset[IDX_W+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (enter_resp) begin
                rdata_q <= (acc_we || acc_err) ? 32'd0 : ram_q[idx];
                error_q <= acc_err;
            end
        end
    end

    // RAM contents deliberately survive reset; only the pending commit is suppressed.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && acc_we && !acc_err) begin
            ram_q[idx] <= acc_wdata;
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: four builds (LATENCY 2, 1, 5, 3) checked against
// a queue of expected responses pushed at acceptance and popped at the due cycle.
module tb_data_memory_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          due;
    } exp_t;

    function automatic int lat_of(input int g);
        case (g)
            0:       return 2;
            1:       return 1;
            2:       return 5;
            default: return 3;
        endcase
    endfunction

    logic        clk;
    logic        rst        [4];
    logic        req        [4];
    logic        we         [4];
    logic [31:0] addr       [4];
    logic [31:0] wdata      [4];
    logic        ready      [4];
    logic        resp_valid [4];
    logic [31:0] rdata      [4];
    logic        error      [4];

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [31:0] nxt_rdata;
    logic        nxt_err;
    logic        accepted;
    int          last_acc;
    int          first_due;
    int          store_acc;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        data_memory_responder #(
            .DEPTH_WORDS(1024),
            .BASE_ADDR  (32'h1001_0000),
            .LATENCY    (lat_of(g))
        ) dut (
            .clk       (clk),
            .reset     (rst[g]),
            .req       (req[g]),
            .we        (we[g]),
            .addr      (addr[g]),
            .wdata     (wdata[g]),
            .ready     (ready[g]),
            .resp_valid(resp_valid[g]),
            .rdata     (rdata[g]),
            .error     (error[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One cycle: check ready/response at the falling edge, record acceptance, return after next rising edge.
    task automatic tick(input int g);
        exp_t e;
        logic exp_rdy;
        logic exp_resp;
        @(negedge clk);
        exp_rdy  = 1'b1;
        exp_resp = 1'b0;
        if (sb.size() > 0) begin
            if (cyc > sb[0].acc && cyc < sb[0].due) exp_rdy = 1'b0;
            if (cyc == sb[0].due) exp_resp = 1'b1;
        end
        chk("ready", 32'(ready[g]), 32'(exp_rdy));
        chk("resp_valid", 32'(resp_valid[g]), 32'(exp_resp));
        if (exp_resp) begin
            e = sb.pop_front();
            chk("rdata", rdata[g], e.rdata);
            chk("error", 32'(error[g]), 32'(e.err));
        end
        accepted = 1'b0;
        if (req[g] && ready[g]) begin
            e.rdata  = nxt_rdata;
            e.err    = nxt_err;
            e.acc    = cyc;
            e.due    = cyc + lat_of(g);
            sb.push_back(e);
            accepted = 1'b1;
            last_acc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int g, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] er, input logic ee);
        req[g]    = 1'b1;
        we[g]     = w;
        addr[g]   = a;
        wdata[g]  = d;
        nxt_rdata = er;
        nxt_err   = ee;
        for (int i = 0; i < 20; i++) begin
            tick(g);
            if (accepted) break;
        end
        chk("accepted", 32'(accepted), 32'd1);
        req[g] = 1'b0;
    endtask

    task automatic drain(input int g);
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            tick(g);
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic txn(input int g, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee);
        present(g, w, a, d, er, ee);
        drain(g);
    endtask

    initial begin
        for (int g = 0; g < 4; g++) begin
            rst[g] = 1'b1; req[g] = 1'b0; we[g] = 1'b0; addr[g] = 32'd0; wdata[g] = 32'd0;
        end
        nxt_rdata = 32'd0; nxt_err = 1'b0; accepted = 1'b0; last_acc = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) rst[g] = 1'b0;

        // LATENCY=2: reset state
        tick(0);
        chk("rst_rdata", rdata[0], 32'd0);
        chk("rst_error", 32'(error[0]), 32'd0);

        txn(0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 32'd0, 1'b0);
        txn(0, 1'b0, 32'h1001_0008, 32'd0, 32'hDEAD_BEEF, 1'b0);
        chk("rdata_hold", rdata[0], 32'hDEAD_BEEF);
        txn(0, 1'b1, 32'h1001_000C, 32'h1234_5678, 32'd0, 1'b0);
        txn(0, 1'b0, 32'h1001_000C, 32'd0, 32'h1234_5678, 1'b0);

        // error cases around a known boundary word and word 0
        txn(0, 1'b1, 32'h1001_0FFC, 32'hA5A5_A5A5, 32'd0, 1'b0);
        txn(0, 1'b1, 32'h1001_0000, 32'h00C0_FFEE, 32'd0, 1'b0);
        txn(0, 1'b1, 32'h1001_0004, 32'h4444_4444, 32'd0, 1'b0);
        txn(0, 1'b0, 32'h1001_0002, 32'd0, 32'd0, 1'b1);
        txn(0, 1'b1, 32'h1001_1000, 32'hBAD0_BAD0, 32'd0, 1'b1);
        txn(0, 1'b1, 32'h1001_0006, 32'hBAD1_BAD1, 32'd0, 1'b1);
        txn(0, 1'b0, 32'h0FFF_FFFC, 32'd0, 32'd0, 1'b1);
        txn(0, 1'b0, 32'h1001_0FFC, 32'd0, 32'hA5A5_A5A5, 1'b0);
        txn(0, 1'b0, 32'h1001_0004, 32'd0, 32'h4444_4444, 1'b0);

        // back-to-back loads with req held high across the wait cycle
        present(0, 1'b0, 32'h1001_0000, 32'd0, 32'h00C0_FFEE, 1'b0);
        first_due = last_acc + 2;
        present(0, 1'b0, 32'h1001_0004, 32'd0, 32'h4444_4444, 1'b0);
        chk("b2b_accept_cycle", 32'(last_acc), 32'(first_due));
        drain(0);

        // LATENCY=1: store then load on consecutive accept edges
        present(1, 1'b1, 32'h1001_0010, 32'h600D_CAFE, 32'd0, 1'b0);
        store_acc = last_acc;
        present(1, 1'b0, 32'h1001_0010, 32'd0, 32'h600D_CAFE, 1'b0);
        chk("lat1_consecutive", 32'(last_acc), 32'(store_acc + 1));
        drain(1);
        txn(1, 1'b0, 32'h1001_1004, 32'd0, 32'd0, 1'b1);

        // LATENCY=5
        txn(2, 1'b1, 32'h1001_0040, 32'h5555_5555, 32'd0, 1'b0);
        txn(2, 1'b0, 32'h1001_0040, 32'd0, 32'h5555_5555, 1'b0);

        // LATENCY=3: reset one cycle after accepting a store aborts it
        txn(3, 1'b1, 32'h1001_0020, 32'h1111_1111, 32'd0, 1'b0);
        present(3, 1'b1, 32'h1001_0020, 32'hCAFE_F00D, 32'd0, 1'b0);
        rst[3] = 1'b1;
        tick(3);
        rst[3] = 1'b0;
        sb.delete();
        repeat (5) tick(3);
        chk("post_rst_rdata", rdata[3], 32'd0);
        txn(3, 1'b0, 32'h1001_0020, 32'd0, 32'h1111_1111, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
